// File: rtl/fp_adder_pkg.sv
// Shared constants and field layout for the binary32 adder.
// The 27-bit normalization vector is the 24-bit significand plus guard, round and sticky bits.
package fp_adder_pkg;

  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;
  localparam int NORM_W  = FRAC_W + 4;
  localparam int LZC_W   = 5;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp_t;

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter for the normalization vector.
// An all-zero vector reports NORM_W.
module fp_lzc
  import fp_adder_pkg::*;
(
  input  logic [NORM_W-1:0] vec,
  output logic [LZC_W-1:0]  count
);

  // The highest set bit is visited last, so its count wins.
  always_comb begin
    count = LZC_W'(NORM_W);
    for (int i = 0; i < NORM_W; i++) begin
      if (vec[i]) count = LZC_W'(NORM_W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_adder.sv
// IEEE-754 binary32 adder, round-to-nearest-even, one registered cycle of latency.
// All arithmetic is combinational from A/B into the Sum register.
module fp_adder
  import fp_adder_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Sum
);

  fp_t a_f, b_f;
  assign a_f = A;
  assign b_f = B;

  logic a_nan, b_nan, a_inf, b_inf;
  assign a_nan = (a_f.exp == EXP_W'(EXP_MAX)) && (a_f.frac != '0);
  assign b_nan = (b_f.exp == EXP_W'(EXP_MAX)) && (b_f.frac != '0);
  assign a_inf = (a_f.exp == EXP_W'(EXP_MAX)) && (a_f.frac == '0);
  assign b_inf = (b_f.exp == EXP_W'(EXP_MAX)) && (b_f.frac == '0);

  // Magnitude ordering works directly on the exponent/fraction bits.
  logic a_ge_b;
  assign a_ge_b = (A[30:0] >= B[30:0]);

  logic [EXP_W-1:0]  exp_big, exp_small, e_big, e_small, shift_d;
  logic [FRAC_W-1:0] frac_big, frac_small;
  logic [23:0]       m_big, m_small;
  logic              sign_big, eff_sub;

  assign sign_big   = a_ge_b ? a_f.sign : b_f.sign;
  assign exp_big    = a_ge_b ? a_f.exp  : b_f.exp;
  assign exp_small  = a_ge_b ? b_f.exp  : a_f.exp;
  assign frac_big   = a_ge_b ? a_f.frac : b_f.frac;
  assign frac_small = a_ge_b ? b_f.frac : a_f.frac;
  assign eff_sub    = a_f.sign ^ b_f.sign;

  // Subnormals: hidden bit 0, effective exponent 1.
  assign e_big   = (exp_big   == '0) ? EXP_W'(1) : exp_big;
  assign e_small = (exp_small == '0) ? EXP_W'(1) : exp_small;
  assign m_big   = {exp_big   != '0, frac_big};
  assign m_small = {exp_small != '0, frac_small};
  assign shift_d = e_big - e_small;

  logic [NORM_W-1:0] big_ext, small_ext, shifted, aligned;
  logic              lost;
  assign big_ext   = {m_big, 3'b000};
  assign small_ext = {m_small, 3'b000};
  assign shifted   = small_ext >> shift_d;
  assign lost      = |(small_ext & ~({NORM_W{1'b1}} << shift_d));
  assign aligned   = {shifted[NORM_W-1:1], shifted[0] | lost};

  logic [NORM_W:0]   sum_raw;
  logic [NORM_W-1:0] diff_raw;
  logic [LZC_W-1:0]  lz;
  assign sum_raw  = {1'b0, big_ext} + {1'b0, aligned};
  assign diff_raw = big_ext - aligned;

  fp_lzc u_lzc (
    .vec   (diff_raw),
    .count (lz)
  );

  logic [NORM_W-1:0] norm;
  logic [EXP_W:0]    exp_n, exp_f;
  logic [EXP_W-1:0]  lz_ext, lsh_max, lsh;

  // Left normalization stops at exponent 1, leaving a subnormal when needed.
  always_comb begin
    lz_ext  = {3'b000, lz};
    lsh_max = e_big - EXP_W'(1);
    lsh     = (lz_ext > lsh_max) ? lsh_max : lz_ext;
    norm    = '0;
    exp_n   = '0;
    if (!eff_sub) begin
      if (sum_raw[NORM_W]) begin
        norm  = {sum_raw[NORM_W:2], |sum_raw[1:0]};
        exp_n = {1'b0, e_big} + 9'd1;
      end else begin
        norm  = sum_raw[NORM_W-1:0];
        exp_n = {1'b0, e_big};
      end
    end else begin
      norm  = diff_raw << lsh;
      exp_n = {1'b0, e_big} - {1'b0, lsh};
    end
    exp_f = norm[NORM_W-1] ? exp_n : '0;
  end

  // Incrementing exponent|fraction as one integer carries a rounding overflow
  // into the exponent, including subnormal -> 2^-126 and max-normal -> inf.
  logic        round_up, sign_r;
  logic [30:0] rounded;
  assign round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
  assign rounded  = {exp_f[EXP_W-1:0], norm[25:3]} + 31'(round_up);
  assign sign_r   = (eff_sub && (diff_raw == '0)) ? 1'b0 : sign_big;

  logic [31:0] result;
  always_comb begin
    result = {sign_r, rounded};
    if (a_nan || b_nan || (a_inf && b_inf && eff_sub)) result = QNAN;
    else if (a_inf)                                    result = A;
    else if (b_inf)                                    result = B;
    else if (exp_n >= 9'(EXP_MAX))                     result = {sign_r, 8'hFF, 23'h0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) Sum <= '0;
    else        Sum <= result;
  end

endmodule

// File: tb/tb_fp_adder.sv
// Bench for fp_adder: exact big-integer reference model, directed corner vectors,
// randomized operands, and asynchronous reset behaviour.
module tb_fp_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [31:0] Sum;

  logic [31:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  fp_adder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .Sum   (Sum)
  );

  always #5 clk = ~clk;

  // Operand magnitude as an integer multiple of 2^-149.
  function automatic logic [299:0] mag(input logic [31:0] x);
    logic [299:0] m;
    m = 300'(x[22:0]);
    if (x[30:23] != 8'h00) m = (m | (300'(1) << 23)) << (x[30:23] - 8'd1);
    return m;
  endfunction

  // Exact sum, then round-to-nearest-even onto the binary32 grid.
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic         sa, sb, s;
    logic [299:0] ma, mb, m, q, rem, half;
    int           p, sh, e;
    sa = a[31];
    sb = b[31];
    if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0))
      return 32'h7FC00000;
    if (a[30:0] == 31'h7F800000 && b[30:0] == 31'h7F800000 && sa != sb) return 32'h7FC00000;
    if (a[30:0] == 31'h7F800000) return a;
    if (b[30:0] == 31'h7F800000) return b;
    ma = mag(a);
    mb = mag(b);
    if (sa == sb) begin m = ma + mb; s = sa; end
    else if (ma > mb) begin m = ma - mb; s = sa; end
    else begin m = mb - ma; s = sb; end
    if (m == 0) return (sa && sb) ? 32'h80000000 : 32'h00000000;
    if (m < (300'(1) << 24)) return {s, m[30:0]};
    p = 0;
    for (int i = 0; i < 300; i++) if (m[i]) p = i;
    sh   = p - 23;
    q    = m >> sh;
    rem  = m & ((300'(1) << sh) - 300'(1));
    half = 300'(1) << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 300'(1);
    if (q[24]) begin q = q >> 1; sh++; end
    e = sh + 1;
    if (e >= 255) return {s, 8'hFF, 23'h0};
    return {s, 8'(e), q[22:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h", name, got, want);
    end
  endtask

  task automatic apply(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    A = a;
    B = b;
    exp_q.push_back(ref_add(a, b));
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: %0d results still pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  function automatic logic [31:0] rand_op(input logic [31:0] other);
    logic [31:0] specials[10];
    int          e;
    specials = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000, 32'h7FC00000,
                 32'h7F800001, 32'h00000001, 32'h7F7FFFFF, 32'h80800000, 32'h007FFFFF};
    case ($urandom_range(0, 7))
      0, 1:    return $urandom();
      2:       return {1'($urandom_range(0, 1)), 8'h00, 23'($urandom())};
      3:       return specials[$urandom_range(0, 9)];
      4, 5: begin
        e = int'(other[30:23]) + $urandom_range(0, 4) - 2;
        if (e < 0) e = 0;
        if (e > 254) e = 254;
        return {1'($urandom_range(0, 1)), 8'(e),
                other[22:0] ^ (23'(1) << $urandom_range(0, 22))};
      end
      default: return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom())};
    endcase
  endfunction

  // Single compare process: one registered result per clock while out of reset.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) check("pipe", Sum, exp_q.pop_front());
    end
  end

  logic [31:0] dir_a[17];
  logic [31:0] dir_b[17];
  logic [31:0] dir_s[17];

  initial begin
    logic [31:0] ra;
    dir_a = '{32'h3F800000, 32'h3E800000, 32'h3F800000, 32'hBE800000, 32'h00000001, 32'h3F800000,
              32'h7F800000, 32'h7F7FFFFF, 32'h3F800000, 32'h80000000, 32'h00000000, 32'h7F800001,
              32'h7F800000, 32'h00000000, 32'h007FFFFF, 32'h3F800001, 32'h7F7FFFFF};
    dir_b = '{32'h3F000000, 32'h3E000000, 32'hBF000000, 32'h3E000000, 32'h00000001, 32'hBF800000,
              32'hFF800000, 32'h7F7FFFFF, 32'h33800000, 32'h80000000, 32'h80000000, 32'h3F800000,
              32'hC0000000, 32'hBF800000, 32'h00000001, 32'h33800000, 32'h73000000};
    dir_s = '{32'h3FC00000, 32'h3EC00000, 32'h3F000000, 32'hBE000000, 32'h00000002, 32'h00000000,
              32'h7FC00000, 32'h7F800000, 32'h3F800000, 32'h80000000, 32'h00000000, 32'h7FC00000,
              32'h7F800000, 32'hBF800000, 32'h00800000, 32'h3F800002, 32'h7F800000};

    #3;
    check("reset_initial", Sum, 32'h00000000);
    @(negedge clk);
    rst_n = 1'b1;

    // Hand-computed values pin the model, then the same vectors go to the DUT.
    for (int i = 0; i < 17; i++) check($sformatf("model_dir%0d", i), ref_add(dir_a[i], dir_b[i]), dir_s[i]);
    check("model_sub_cancel", ref_add(32'h00800000, 32'h807FFFFF), 32'h00000001);
    for (int i = 0; i < 17; i++) apply(dir_a[i], dir_b[i]);
    apply(32'h00800000, 32'h807FFFFF);

    for (int i = 0; i < 3000; i++) begin
      ra = rand_op(32'h3F800000);
      apply(ra, rand_op(ra));
    end
    drain("drain_random");

    // Asynchronous reset between edges, held across an edge, then released.
    apply(32'h3F800000, 32'h3F000000);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("reset_async", Sum, 32'h00000000);
    @(negedge clk);
    A = 32'h40400000;
    B = 32'h3F800000;
    @(posedge clk);
    #1;
    check("reset_hold", Sum, 32'h00000000);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(32'h40800000);
    drain("drain_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
